// File: rtl/regfile_operand_read.sv
// Operand-read stage in front of the duplex register-file SRAM.
// It drives the SRAM read ports, merges writeback bypass into the returned data, and holds operands until handed off.
module regfile_operand_read #(
    parameter int N_SRC   = 2,
    parameter int W_PORTS = 2,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int TAG_W   = 6,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_flush,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  logic [TAG_W-1:0]                 i_in_tag,
    input  logic [N_SRC-1:0]                 i_in_rs_e,
    input  logic [N_SRC-1:0][AW-1:0]         i_in_rs_addr,
    output logic [N_SRC-1:0]                 o_rf_r_e,
    output logic [N_SRC-1:0][AW-1:0]         o_rf_r_addr,
    input  logic [N_SRC-1:0][WIDTH-1:0]      i_rf_r_data,
    input  logic [W_PORTS-1:0]               i_wb_e,
    input  logic [W_PORTS-1:0][AW-1:0]       i_wb_addr,
    input  logic [W_PORTS-1:0][WIDTH-1:0]    i_wb_data,
    output logic                             o_out_valid,
    input  logic                             i_out_ready,
    output logic [TAG_W-1:0]                 o_out_tag,
    output logic [N_SRC-1:0][WIDTH-1:0]      o_out_data
);

    logic                         r_hold_v;
    logic [TAG_W-1:0]             r_tag;
    logic [N_SRC-1:0][AW-1:0]     r_addr;
    logic [N_SRC-1:0]             r_en;
    logic [N_SRC-1:0]             r_byp_v;
    logic [N_SRC-1:0][WIDTH-1:0]  r_byp_d;

    logic                         w_accept;
    logic                         w_leave;
    logic [N_SRC-1:0]             w_in_hit;
    logic [N_SRC-1:0][WIDTH-1:0]  w_in_dat;
    logic [N_SRC-1:0]             w_hold_hit;
    logic [N_SRC-1:0][WIDTH-1:0]  w_hold_dat;

    assign o_in_ready = !i_rst && !i_flush && (!r_hold_v || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_leave    = r_hold_v && i_out_ready;

    assign o_rf_r_e    = w_accept ? i_in_rs_e : '0;
    assign o_rf_r_addr = i_in_rs_addr;

    // Scan ports high-to-low so the lowest matching port ends up winning, as in the SRAM.
    always_comb begin
        w_in_hit   = '0;
        w_in_dat   = '0;
        w_hold_hit = '0;
        w_hold_dat = '0;
        for (int s = 0; s < N_SRC; s++) begin
            for (int p = W_PORTS - 1; p >= 0; p--) begin
                if (i_wb_e[p] && i_wb_addr[p] == i_in_rs_addr[s] && i_in_rs_addr[s] != '0) begin
                    w_in_hit[s] = 1'b1;
                    w_in_dat[s] = i_wb_data[p];
                end
                if (i_wb_e[p] && i_wb_addr[p] == r_addr[s] && r_addr[s] != '0) begin
                    w_hold_hit[s] = 1'b1;
                    w_hold_dat[s] = i_wb_data[p];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_v <= 1'b0;
            r_tag    <= '0;
            r_addr   <= '0;
            r_en     <= '0;
            r_byp_v  <= '0;
            r_byp_d  <= '0;
        end else if (i_flush) begin
            r_hold_v <= 1'b0;
            r_byp_v  <= '0;
        end else if (w_accept) begin
            r_hold_v <= 1'b1;
            r_tag    <= i_in_tag;
            r_addr   <= i_in_rs_addr;
            r_en     <= i_in_rs_e;
            r_byp_v  <= w_in_hit;
            r_byp_d  <= w_in_dat;
        end else if (w_leave) begin
            r_hold_v <= 1'b0;
            r_byp_v  <= '0;
        end else if (r_hold_v) begin
            // Stalled: the SRAM output is frozen, so later writes must be tracked here.
            for (int s = 0; s < N_SRC; s++) begin
                if (w_hold_hit[s]) begin
                    r_byp_v[s] <= 1'b1;
                    r_byp_d[s] <= w_hold_dat[s];
                end
            end
        end
    end

    always_comb begin
        o_out_data = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (r_hold_v && r_en[s] && r_addr[s] != '0)
                o_out_data[s] = r_byp_v[s] ? r_byp_d[s] : i_rf_r_data[s];
        end
    end

    assign o_out_valid = r_hold_v;
    assign o_out_tag   = r_tag;

endmodule

// File: tb/tb_regfile_operand_read.sv
// Bench for regfile_operand_read: a behavioural SRAM feeds the DUT, and an architectural register model predicts every operand.
// Directed vectors follow the hazard, stall, r0, flush and reset scenarios.
module tb_regfile_operand_read;

    localparam int NS = 2;
    localparam int NP = 2;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int TW = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [TW-1:0]          in_tag;
    logic [NS-1:0]          rs_e;
    logic [NS-1:0][AW-1:0]  rs_addr;
    logic [NS-1:0]          rf_r_e;
    logic [NS-1:0][AW-1:0]  rf_r_addr;
    logic [NS-1:0][W-1:0]   rf_r_data;
    logic [NP-1:0]          wb_e;
    logic [NP-1:0][AW-1:0]  wb_addr;
    logic [NP-1:0][W-1:0]   wb_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [TW-1:0]          out_tag;
    logic [NS-1:0][W-1:0]   out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_operand_read dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_tag(in_tag),
        .i_in_rs_e(rs_e), .i_in_rs_addr(rs_addr),
        .o_rf_r_e(rf_r_e), .o_rf_r_addr(rf_r_addr), .i_rf_r_data(rf_r_data),
        .i_wb_e(wb_e), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_tag(out_tag), .o_out_data(out_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Duplex SRAM: registered read of the pre-write value, output held when not read, lowest write port wins.
    logic [W-1:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rf_r_data = '0;
    end
    always @(posedge clk) begin
        for (int s = 0; s < NS; s++)
            if (rf_r_e[s]) rf_r_data[s] <= mem[rf_r_addr[s]];
        for (int p = NP - 1; p >= 0; p--)
            if (wb_e[p]) mem[wb_addr[p]] = wb_data[p];
    end

    // Model: an operand is the architectural value of its register as of the last clock edge.
    logic [W-1:0]          arch [32];
    logic                  exp_valid = 1'b0;
    logic [TW-1:0]         exp_tag   = '0;
    logic [NS-1:0][AW-1:0] exp_addr  = '0;
    logic [NS-1:0]         exp_en    = '0;
    initial for (int i = 0; i < 32; i++) arch[i] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid = 1'b0;
            exp_tag   = '0;
        end else begin
            logic acc;
            acc = in_valid && !flush && (!exp_valid || out_ready);
            if (flush) exp_valid = 1'b0;
            else if (acc) begin
                exp_valid = 1'b1;
                exp_tag   = in_tag;
                exp_addr  = rs_addr;
                exp_en    = rs_e;
            end else if (exp_valid && out_ready) exp_valid = 1'b0;
            for (int p = NP - 1; p >= 0; p--)
                if (wb_e[p]) arch[wb_addr[p]] = wb_data[p];
        end
    end

    always @(negedge clk) begin
        logic           rdy;
        logic [NS-1:0]  ere;
        logic [W-1:0]   ed;
        rdy = !rst && !flush && (!exp_valid || out_ready);
        ere = (in_valid && rdy) ? rs_e : '0;
        chk("in_ready", in_ready, rdy);
        chk("rf_r_e", rf_r_e, ere);
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) chk("out_tag", out_tag, exp_tag);
        for (int s = 0; s < NS; s++) begin
            if (ere[s]) chk("rf_r_addr", rf_r_addr[s], rs_addr[s]);
            ed = (exp_valid && exp_en[s] && exp_addr[s] != '0) ? arch[exp_addr[s]] : '0;
            chk("out_data", out_data[s], ed);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush = 0; in_valid = 0; wb_e = '0; out_ready = 1;
    endtask

    task automatic issue(input logic [TW-1:0] t, input logic [NS-1:0] e,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        in_valid = 1; in_tag = t; rs_e = e;
        rs_addr[0] = a0; rs_addr[1] = a1;
    endtask

    task automatic wb(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
        wb_e[p] = 1'b1; wb_addr[p] = a; wb_data[p] = d;
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_tag = '0; rs_e = '0; rs_addr = '0;
        wb_e = '0; wb_addr = '0; wb_data = '0; out_ready = 1;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_rf_r_e", rf_r_e, 0);
        chk("rst_in_ready", in_ready, 0);
        tick; tick;
        rst = 0;

        wb(0, 5, 32'h11); wb(1, 6, 32'h22); tick;
        idle; wb(0, 9, 32'h5); wb(1, 3, 32'h99); tick;

        idle; issue(6'h15, 2'b11, 5, 6); #1;
        chk("basic_rf_r_e", rf_r_e, 2'b11);
        tick;
        chk("basic_valid", out_valid, 1);
        chk("basic_d0", out_data[0], 32'h11);
        chk("basic_d1", out_data[1], 32'h22);
        chk("basic_tag", out_tag, 6'h15);

        idle; issue(6'h2A, 2'b11, 7, 5); wb(0, 7, 32'hAB); tick;
        chk("hazard_d0", out_data[0], 32'hAB);
        chk("hazard_d1", out_data[1], 32'h11);

        idle; issue(6'h0B, 2'b01, 3, 6); wb(0, 3, 32'h1); wb(1, 3, 32'h2); tick;
        chk("multiport_d0", out_data[0], 32'h1);
        chk("multiport_d1_disabled", out_data[1], 0);

        idle; issue(6'h33, 2'b01, 9, 0); tick;
        chk("stall_old", out_data[0], 32'h5);
        idle; out_ready = 0; issue(6'h34, 2'b11, 5, 5); wb(0, 9, 32'h6); #1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_rf_r_e", rf_r_e, 0);
        tick;
        wb_e = '0; wb(1, 9, 32'h7); tick;
        wb_e = '0; tick;
        chk("stall_valid", out_valid, 1);
        chk("stall_d0", out_data[0], 32'h7);
        chk("stall_tag", out_tag, 6'h33);
        idle; tick;
        chk("stall_drained", out_valid, 0);

        idle; issue(6'h20, 2'b11, 0, 0); wb(0, 0, 32'hFF); tick;
        chk("r0_valid", out_valid, 1);
        chk("r0_data", out_data, 0);

        idle; out_ready = 0; flush = 1; issue(6'h3C, 2'b11, 5, 6); #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_rf_r_e", rf_r_e, 0);
        tick;
        chk("flush_valid", out_valid, 0);

        idle; issue(6'h3C, 2'b11, 6, 5); tick;
        chk("post_flush_d0", out_data[0], 32'h22);
        chk("post_flush_d1", out_data[1], 32'h11);
        idle; out_ready = 0; #3;
        rst = 1; #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_tag", out_tag, 0);
        chk("async_rst_in_ready", in_ready, 0);
        tick;
        rst = 0; idle; tick;

        issue(6'h01, 2'b11, 9, 3); tick;
        chk("final_d0", out_data[0], 32'h7);
        chk("final_d1", out_data[1], 32'h1);
        idle; tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_operand_read.md
Name: regfile_operand_read

Overview:
- Operand-read stage placed directly in front of the duplex register-file SRAM: accepts issued instructions and drives the SRAM read ports.
- One cycle later, merges the registered SRAM read data with same-cycle and in-flight writeback bypass, then presents operands downstream with a valid/ready handshake.
- Forces register 0 to read as zero.
- Keeps held operands coherent with writebacks while the downstream stage stalls.

Parameters:
- N_SRC, 2, number of source operands per instruction; equals the number of SRAM read ports used.
- W_PORTS, 2, number of writeback ports; mirrors the SRAM write ports.
- WIDTH, 32, register data width.
- DEPTH, 32, register count; AW = $clog2(DEPTH).
- TAG_W, 6, width of the opaque instruction tag carried alongside.

Ports:
- i_clk  in  1  clock, all state on posedge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  kill the held instruction and block acceptance this cycle.
- i_in_valid  in  1  upstream request valid.
- o_in_ready  out  1  stage can accept.
- i_in_tag  in  TAG_W  instruction tag.
- i_in_rs_e  in  N_SRC  per-source read enable.
- i_in_rs_addr  in  AW x N_SRC  source register numbers.
- o_rf_r_e  out  N_SRC  to SRAM read enables.
- o_rf_r_addr  out  AW x N_SRC  to SRAM read addresses.
- i_rf_r_data  in  WIDTH x N_SRC  from SRAM, valid the cycle after the read.
- i_wb_e  in  W_PORTS  writeback enables; same signals feed the SRAM.
- i_wb_addr  in  AW x W_PORTS  writeback addresses.
- i_wb_data  in  WIDTH x W_PORTS  writeback data.
- o_out_valid  out  1  operands valid.
- i_out_ready  in  1  downstream accepts.
- o_out_tag  out  TAG_W  tag of the held instruction.
- o_out_data  out  WIDTH x N_SRC  resolved operands.

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst is asynchronous and active-high.
- Ready: o_in_ready = !i_flush & (!hold_v | i_out_ready). Accept = i_in_valid & o_in_ready.
- SRAM drive (combinational, accept cycle only):
  - o_rf_r_e[s] = accept & i_in_rs_e[s].
  - o_rf_r_addr[s] = i_in_rs_addr[s].
  - When not accepting, o_rf_r_e = 0, so the SRAM output holds its value.
- Capture on accept: hold_v <= 1; register tag, addr[s], en[s]; set byp_v[s]/byp_d[s] from a wb match (below).
- Wb match for source s: i_wb_e[p] & i_wb_addr[p]==addr & addr!=0. The lowest-index matching port wins, matching the SRAM's internal write resolution.
- Accept-cycle bypass: the SRAM returns the pre-write value when read and write hit the same address, so a wb match in the accept cycle sets byp_v[s] and captures that data.
- Hold-cycle snoop: every cycle hold_v=1 and the instruction is not leaving, a wb match on held addr[s] sets byp_v[s] and overwrites byp_d[s]. The newest write wins.
- Operand output:
  - o_out_data[s] = 0 if !hold_v, !en[s], or addr[s]==0.
  - Otherwise byp_d[s] if byp_v[s].
  - Otherwise i_rf_r_data[s].
- Output valid: o_out_valid = hold_v.
- Latency: 1 cycle accept-to-valid. Throughput: 1 per cycle when i_out_ready stays high.
- Handoff: o_out_valid & i_out_ready clears hold_v, unless a new accept in the same cycle reloads it, in which case byp state is recomputed for the new instruction.
- Flush: hold_v <= 0 and no accept. Flush has priority over handoff and accept.
- Reset: hold_v=0, byp_v=0, tag/addr/en/byp_d=0.
  - After reset: o_out_valid=0, o_out_data=0, o_out_tag=0, o_rf_r_e=0.
  - While i_rst is high, o_in_ready=0.
  - Reset mid-operation discards the held instruction.
- Wb to register 0 never bypasses.
- Wb while hold_v=0 has no effect.

Test Plan:
- Basic read: preload r5=0x11, r6=0x22. Issue rs=(5,6), out_ready=1 → o_out_valid next cycle, data=(0x11,0x22), tag echoed.
- Same-cycle hazard: issue rs1=r7 while wb port0 writes r7=0xAB in the same cycle (SRAM returns old 0x00) → o_out_data[0]=0xAB.
- Multi-port conflict: accept-cycle wb p0 r3=0x1, p1 r3=0x2 → operand r3=0x1 (lowest port wins).
- Stall snoop: hold r9 (old 0x5) with out_ready=0 for 3 cycles; wb r9=0x6 in cycle 1 and r9=0x7 in cycle 2 → output 0x7 when out_ready=1; o_in_ready=0 during the stall.
- r0 handling: issue rs=(0,0) with wb to r0=0xFF the same cycle → data=(0,0).
- Flush/reset: hold an instruction, assert i_flush → o_out_valid=0 next cycle, and no accept that cycle despite i_in_valid. Assert i_rst asynchronously mid-hold → o_out_valid drops immediately and all outputs read 0.
